ram_bist_ctrl: RTL and testbench

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_pkg.sv | 33 +++
 rtl/ram_bist_ctrl.sv | 154 +++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM BIST controller: geometry,
// sequencer states and the test pattern generator.
package ram_pkg;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    localparam logic [7:0] ERR_MAX = 8'd128;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        RD0,
        DRN0,
        WR1,
        RD1,
        DRN1,
        DONE
    } state_t;

    // P0 is seed ^ addr; P1 is its complement
    function automatic logic [DW-1:0] pat(
        input logic [DW-1:0] s,
        input logic [AW-1:0] a,
        input logic          inv
    );
        logic [DW-1:0] p;
        p = s ^ DW'(a);
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ram_bist_ctrl.sv
// Two-pass RAM self-test: write/read pattern P0, then P1, with a
// one-cycle pipelined compare and first-failure capture.
module ram_bist_ctrl #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] seed,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          we,
    input  logic [DW-1:0] out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_count,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_exp,
    output logic [DW-1:0] fail_got
);

    import ram_pkg::*;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic          last;
    logic          sweep;
    logic [DW-1:0] seed_q;
    logic          cmp_v;
    logic          cmp_inv;
    logic [AW-1:0] cmp_a;
    logic [DW-1:0] exp_w;
    logic          miss;
    logic [7:0]    err_q;
    logic [7:0]    err_nxt;
    logic          pass_q;

    assign last  = &cnt;
    assign sweep = (state == WR0) || (state == RD0) ||
                   (state == WR1) || (state == RD1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = WR0;
            WR0:     if (last)  state_nxt = RD0;
            RD0:     if (last)  state_nxt = DRN0;
            DRN0:    state_nxt = WR1;
            WR1:     if (last)  state_nxt = RD1;
            RD1:     if (last)  state_nxt = DRN1;
            DRN1:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        we   = 1'b0;
        data = '0;
        addr = '0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            WR0: begin
                we   = 1'b1;
                data = pat(seed_q, cnt, 1'b0);
                addr = cnt;
                busy = 1'b1;
            end
            WR1: begin
                we   = 1'b1;
                data = pat(seed_q, cnt, 1'b1);
                addr = cnt;
                busy = 1'b1;
            end
            RD0, RD1: begin
                addr = cnt;
                busy = 1'b1;
            end
            DRN0, DRN1: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // Address counter restarts at zero on every phase change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            cmp_v   <= 1'b0;
            cmp_inv <= 1'b0;
            cmp_a   <= '0;
        end else begin
            cnt     <= sweep ? cnt + 1'b1 : '0;
            cmp_v   <= (state == RD0) || (state == RD1);
            cmp_inv <= (state == RD1);
            cmp_a   <= cnt;
        end
    end

    assign exp_w = pat(seed_q, cmp_a, cmp_inv);
    assign miss  = cmp_v && (out != exp_w);

    always_comb begin
        err_nxt = err_q;
        if (miss && (err_q != ERR_MAX)) begin
            err_nxt = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q    <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if ((state == IDLE) && start) begin
            seed_q    <= seed;
            err_q     <= '0;
            pass_q    <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else begin
            err_q <= err_nxt;
            if (miss && (err_q == 8'd0)) begin
                fail_addr <= cmp_a;
                fail_exp  <= exp_w;
                fail_got  <= out;
            end
            // Final compare lands in DRN1, so the verdict is ready in DONE
            if (state == DRN1) begin
                pass_q <= (err_nxt == 8'd0);
            end
        end
    end

    assign err_count = err_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a 64x8 registered-read
// RAM model and an optional stuck bit at address 50.
module tb_ram_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic [5:0] addr;
    logic [7:0] data;
    logic       we;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [5:0] fail_addr;
    logic [7:0] fail_exp;
    logic [7:0] fail_got;

    logic [7:0] mem [64];
    logic       fault;

    int checks;
    int passed;

    int         r_busy;
    int         r_done;
    logic       r_pass_at_done;
    logic [5:0] r_a [3];
    logic [7:0] r_d [3];
    logic       r_w [3];
    logic [7:0] r_wr2 [2];
    int         r_nwr2;

    ram_bist_ctrl #(.AW(6), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .addr      (addr),
        .data      (data),
        .we        (we),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) mem[addr] <= data;
        out <= mem[addr] | {7'b0, fault && (addr == 6'd50)};
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want)
            $display("FAIL %s: got %0h want %0h", name, got, want);
        else
            passed++;
    endtask

    task automatic do_run(input logic [7:0] s, input int restart_at);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        r_busy = 0;
        r_done = 0;
        r_nwr2 = 0;
        r_pass_at_done = 1'bx;
        for (int i = 0; i < 300; i++) begin
            if (i < 3) begin
                r_a[i] = addr;
                r_d[i] = data;
                r_w[i] = we;
            end
            if (we && addr == 6'd2 && r_nwr2 < 2) begin
                r_wr2[r_nwr2] = data;
                r_nwr2++;
            end
            if (busy) r_busy++;
            if (done) begin
                r_done++;
                r_pass_at_done = pass;
            end
            start = (i == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || addr !== 6'd0 || data !== 8'd0 ||
            busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            $display("FAIL reset_outs: we=%b addr=%0h data=%0h busy=%b done=%b pass=%b want all 0",
                     we, addr, data, busy, done, pass);
        end else passed++;
        checks++;
        if (err_count !== 8'd0 || fail_addr !== 6'd0 ||
            fail_exp !== 8'd0 || fail_got !== 8'd0) begin
            $display("FAIL reset_log: err=%0h fa=%0h fe=%0h fg=%0h want all 0",
                     err_count, fail_addr, fail_exp, fail_got);
        end else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_run;
        do_run(8'hb4, -1);
        chk("first_addr0", {26'd0, r_a[0]}, 32'd0);
        chk("first_data0", {24'd0, r_d[0]}, 32'hb4);
        chk("first_addr1", {26'd0, r_a[1]}, 32'd1);
        chk("first_data1", {24'd0, r_d[1]}, 32'hb5);
        chk("first_addr2", {26'd0, r_a[2]}, 32'd2);
        chk("first_data2", {24'd0, r_d[2]}, 32'hb6);
        chk("first_we",    {29'd0, r_w[0], r_w[1], r_w[2]}, 32'h7);
        chk("good_busy",   r_busy, 32'd258);
        chk("good_done",   r_done, 32'd1);
        chk("good_pass_done", {31'd0, r_pass_at_done}, 32'd1);
        chk("good_pass_held", {31'd0, pass}, 32'd1);
        chk("good_err",    {24'd0, err_count}, 32'd0);
        chk("good_fail_addr", {26'd0, fail_addr}, 32'd0);
    endtask

    task automatic test_fault;
        fault = 1'b1;
        do_run(8'h00, -1);
        fault = 1'b0;
        chk("fault_done", r_done, 32'd1);
        chk("fault_pass", {31'd0, r_pass_at_done}, 32'd0);
        chk("fault_err",  {24'd0, err_count}, 32'd1);
        chk("fault_addr", {26'd0, fail_addr}, 32'd50);
        chk("fault_exp",  {24'd0, fail_exp}, 32'h32);
        chk("fault_got",  {24'd0, fail_got}, 32'h33);
    endtask

    task automatic test_pattern;
        do_run(8'h74, -1);
        chk("pat_nwr2", r_nwr2, 32'd2);
        chk("pat_p0_a2", {24'd0, r_wr2[0]}, 32'h76);
        chk("pat_p1_a2", {24'd0, r_wr2[1]}, 32'h89);
        chk("pat_pass", {31'd0, r_pass_at_done}, 32'd1);
        chk("pat_clear_fail", {24'd0, fail_got}, 32'd0);
    endtask

    task automatic test_back_to_back;
        do_run(8'h3c, 10);
        chk("restart_busy", r_busy, 32'd258);
        chk("restart_done", r_done, 32'd1);
        chk("restart_pass", {31'd0, r_pass_at_done}, 32'd1);
    endtask

    task automatic test_reset_mid;
        int n20;
        int ndone;
        logic hit;
        n20   = 0;
        ndone = 0;
        hit   = 1'b0;
        @(negedge clk);
        seed  = 8'h5a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (we && addr == 6'd20) n20++;
            if (n20 == 2) hit = 1'b1;
            else @(negedge clk);
        end
        chk("mid_reached_wr1_a20", {31'd0, hit}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_we",   {31'd0, we}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_addr", {26'd0, addr}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mid_no_done", ndone, 32'd0);
        do_run(8'h5a, -1);
        chk("post_busy", r_busy, 32'd258);
        chk("post_done", r_done, 32'd1);
        chk("post_pass", {31'd0, r_pass_at_done}, 32'd1);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        start  = 1'b0;
        seed   = 8'h00;
        fault  = 1'b0;
        test_reset;
        test_good_run;
        test_fault;
        test_pattern;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
